// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I/RV64I decode stage: opcodes, ALU encodings,
// immediate formats and the decoded control bundle.
package decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SLL     = 4'b0011;
    localparam logic [3:0] ALU_SUB     = 4'b0100;
    localparam logic [3:0] ALU_SRL     = 4'b0101;
    localparam logic [3:0] ALU_SLTU    = 4'b0110;
    localparam logic [3:0] ALU_XOR     = 4'b0111;
    localparam logic [3:0] ALU_SLT     = 4'b1000;
    localparam logic [3:0] ALU_SRA     = 4'b1001;
    localparam logic [3:0] ALU_INVALID = 4'b1111;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] alu_ctrl;
        logic       regwrite;
        logic       imm_sel;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_size;
        logic       branch;
        logic       jump;
        logic       pc_rel;
        logic       muldiv;
        logic       illegal;
    } decode_ctrl_t;

    localparam decode_ctrl_t CTRL_RESET = '{
        rs1: 5'd0, rs2: 5'd0, rd: 5'd0, alu_ctrl: ALU_INVALID,
        regwrite: 1'b0, imm_sel: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
        mem_size: 3'd0, branch: 1'b0, jump: 1'b0, pc_rel: 1'b0,
        muldiv: 1'b0, illegal: 1'b0
    };

    // {funct7[5], funct3} -> ALU op; unlisted combinations map to ALU_INVALID
    function automatic logic [3:0] alu_from(input logic b5, input logic [2:0] f3);
        logic [3:0] w_alu;
        case ({b5, f3})
            4'b0000: w_alu = ALU_ADD;
            4'b1000: w_alu = ALU_SUB;
            4'b0001: w_alu = ALU_SLL;
            4'b0010: w_alu = ALU_SLT;
            4'b0011: w_alu = ALU_SLTU;
            4'b0100: w_alu = ALU_XOR;
            4'b0101: w_alu = ALU_SRL;
            4'b1101: w_alu = ALU_SRA;
            4'b0110: w_alu = ALU_OR;
            4'b0111: w_alu = ALU_AND;
            default: w_alu = ALU_INVALID;
        endcase
        return w_alu;
    endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-to-execute handshake bundle for the decode stage; master drives the
// fetch side and consumes the decoded bundle, slave is the stage itself.
interface decode_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [4:0]       out_rd;
    logic [XLEN-1:0]  out_imm;
    logic [3:0]       out_alu_ctrl;
    logic             out_regwrite;
    logic             out_imm_sel;
    logic             out_mem_read;
    logic             out_mem_write;
    logic [2:0]       out_mem_size;
    logic             out_branch;
    logic             out_jump;
    logic             out_pc_rel;
    logic             out_muldiv;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_count;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_alu_ctrl, out_regwrite, out_imm_sel, out_mem_read, out_mem_write,
               out_mem_size, out_branch, out_jump, out_pc_rel, out_muldiv,
               out_illegal, illegal_count
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_alu_ctrl, out_regwrite, out_imm_sel, out_mem_read, out_mem_write,
               out_mem_size, out_branch, out_jump, out_pc_rel, out_muldiv,
               out_illegal, illegal_count
    );
endinterface

// File: rtl/decode_comb.sv
// Purely combinational RV32I/RV64I instruction decoder.
// DECODE_M_EXT_EN: when defined, R-type funct7=0000001 decodes as an M-extension op.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output decode_ctrl_t    o_ctrl,
    output logic [XLEN-1:0] o_imm
);
    localparam bit RV64 = (XLEN == 64);

    logic [6:0]   w_opcode;
    logic [6:0]   w_funct7;
    logic [2:0]   w_funct3;
    logic [4:0]   w_rd;
    logic [4:0]   w_rs1;
    logic [4:0]   w_rs2;
    logic         w_sh_lo;
    logic         w_sh_hi;
    logic         w_legal;
    imm_type_e    w_imm_type;
    decode_ctrl_t w_ctrl;
    logic [31:0]  w_imm32;

    assign w_opcode = i_instr[6:0];
    assign w_rd     = i_instr[11:7];
    assign w_funct3 = i_instr[14:12];
    assign w_rs1    = i_instr[19:15];
    assign w_rs2    = i_instr[24:20];
    assign w_funct7 = i_instr[31:25];

    // On RV64 instr[25] is shamt[5], so only the upper six bits qualify the shift
    assign w_sh_lo = RV64 ? (i_instr[31:26] == 6'b000000) : (w_funct7 == 7'b0000000);
    assign w_sh_hi = RV64 ? (i_instr[31:26] == 6'b010000) : (w_funct7 == 7'b0100000);

    always_comb begin
        w_ctrl          = '0;
        w_ctrl.alu_ctrl = ALU_ADD;
        w_imm_type      = IMM_I;
        w_legal         = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_ctrl.rd       = w_rd;
                w_ctrl.rs1      = w_rs1;
                w_ctrl.rs2      = w_rs2;
                w_ctrl.regwrite = 1'b1;
                if (w_funct7 == 7'b0000000) begin
                    w_ctrl.alu_ctrl = alu_from(1'b0, w_funct3);
                    w_legal         = 1'b1;
                end else if (w_funct7 == 7'b0100000 &&
                             (w_funct3 == 3'b000 || w_funct3 == 3'b101)) begin
                    w_ctrl.alu_ctrl = alu_from(1'b1, w_funct3);
                    w_legal         = 1'b1;
                end
`ifdef DECODE_M_EXT_EN
                else if (w_funct7 == 7'b0000001) begin
                    w_ctrl.alu_ctrl = {1'b0, w_funct3};
                    w_ctrl.muldiv   = 1'b1;
                    w_legal         = 1'b1;
                end
`endif
            end
            OP_IMM: begin
                w_ctrl.rd       = w_rd;
                w_ctrl.rs1      = w_rs1;
                w_ctrl.regwrite = 1'b1;
                w_ctrl.imm_sel  = 1'b1;
                case (w_funct3)
                    3'b001: begin
                        w_ctrl.alu_ctrl = ALU_SLL;
                        w_legal         = w_sh_lo;
                    end
                    3'b101: begin
                        w_ctrl.alu_ctrl = i_instr[30] ? ALU_SRA : ALU_SRL;
                        w_legal         = w_sh_lo || w_sh_hi;
                    end
                    default: begin
                        w_ctrl.alu_ctrl = alu_from(1'b0, w_funct3);
                        w_legal         = 1'b1;
                    end
                endcase
            end
            OP_LOAD: begin
                w_ctrl.rd       = w_rd;
                w_ctrl.rs1      = w_rs1;
                w_ctrl.regwrite = 1'b1;
                w_ctrl.imm_sel  = 1'b1;
                w_ctrl.mem_read = 1'b1;
                w_ctrl.mem_size = w_funct3;
                case (w_funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                    3'b011, 3'b110:                         w_legal = RV64;
                    default:                                w_legal = 1'b0;
                endcase
            end
            OP_STORE: begin
                w_ctrl.rs1       = w_rs1;
                w_ctrl.rs2       = w_rs2;
                w_ctrl.imm_sel   = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_ctrl.mem_size  = w_funct3;
                w_imm_type       = IMM_S;
                case (w_funct3)
                    3'b000, 3'b001, 3'b010: w_legal = 1'b1;
                    3'b011:                 w_legal = RV64;
                    default:                w_legal = 1'b0;
                endcase
            end
            OP_BRANCH: begin
                w_ctrl.rs1    = w_rs1;
                w_ctrl.rs2    = w_rs2;
                w_ctrl.branch = 1'b1;
                w_imm_type    = IMM_B;
                w_legal       = 1'b1;
                case (w_funct3)
                    3'b000, 3'b001: w_ctrl.alu_ctrl = ALU_SUB;
                    3'b100, 3'b101: w_ctrl.alu_ctrl = ALU_SLT;
                    3'b110, 3'b111: w_ctrl.alu_ctrl = ALU_SLTU;
                    default:        w_legal         = 1'b0;
                endcase
            end
            OP_LUI, OP_AUIPC: begin
                w_ctrl.rd       = w_rd;
                w_ctrl.regwrite = 1'b1;
                w_ctrl.imm_sel  = 1'b1;
                w_ctrl.pc_rel   = (w_opcode == OP_AUIPC);
                w_imm_type      = IMM_U;
                w_legal         = 1'b1;
            end
            OP_JAL: begin
                w_ctrl.rd       = w_rd;
                w_ctrl.regwrite = 1'b1;
                w_ctrl.jump     = 1'b1;
                w_ctrl.pc_rel   = 1'b1;
                w_imm_type      = IMM_J;
                w_legal         = 1'b1;
            end
            OP_JALR: begin
                w_ctrl.rd       = w_rd;
                w_ctrl.rs1      = w_rs1;
                w_ctrl.regwrite = 1'b1;
                w_ctrl.jump     = 1'b1;
                w_ctrl.imm_sel  = 1'b1;
                w_legal         = (w_funct3 == 3'b000);
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal || w_ctrl.alu_ctrl == ALU_INVALID) begin
            w_ctrl          = '0;
            w_ctrl.alu_ctrl = ALU_INVALID;
            w_ctrl.illegal  = 1'b1;
        end
    end

    always_comb begin
        w_imm32 = '0;
        case (w_imm_type)
            IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U:   w_imm32 = {i_instr[31:12], 12'b0};
            IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign o_ctrl = w_ctrl;
    assign o_imm  = XLEN'($signed(w_imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready output register around decode_comb,
// pipeline flush and a saturating illegal-instruction counter.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic    clk,
    input  logic    rst_n,
    decode_if.slave bus
);
    decode_ctrl_t     w_dec;
    logic [XLEN-1:0]  w_imm;
    logic             w_in_ready;
    logic             w_accept;

    decode_ctrl_t     r_ctrl;
    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_imm;
    logic [CNT_W-1:0] r_count;

    decode_comb #(.XLEN(XLEN)) u_comb (
        .i_instr (bus.in_instr),
        .o_ctrl  (w_dec),
        .o_imm   (w_imm)
    );

    assign w_in_ready = !r_valid || bus.out_ready;
    // A transfer in the same cycle as a flush is dropped entirely
    assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_RESET;
            r_pc    <= '0;
            r_imm   <= '0;
            r_count <= '0;
        end else begin
            if (bus.flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
            end else if (bus.out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                r_ctrl <= w_dec;
                r_pc   <= bus.in_pc;
                r_imm  <= w_imm;
                if (w_dec.illegal && (r_count != {CNT_W{1'b1}})) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = r_valid;
    assign bus.out_pc        = r_pc;
    assign bus.out_imm       = r_imm;
    assign bus.out_rs1       = r_ctrl.rs1;
    assign bus.out_rs2       = r_ctrl.rs2;
    assign bus.out_rd        = r_ctrl.rd;
    assign bus.out_alu_ctrl  = r_ctrl.alu_ctrl;
    assign bus.out_regwrite  = r_ctrl.regwrite;
    assign bus.out_imm_sel   = r_ctrl.imm_sel;
    assign bus.out_mem_read  = r_ctrl.mem_read;
    assign bus.out_mem_write = r_ctrl.mem_write;
    assign bus.out_mem_size  = r_ctrl.mem_size;
    assign bus.out_branch    = r_ctrl.branch;
    assign bus.out_jump      = r_ctrl.jump;
    assign bus.out_pc_rel    = r_ctrl.pc_rel;
    assign bus.out_muldiv    = r_ctrl.muldiv;
    assign bus.out_illegal   = r_ctrl.illegal;
    assign bus.illegal_count = r_count;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I/RV64I decode stage between fetch and execute.
- Replaces the single-cycle combinational control decoder.
- Adds the following over that decoder:
  - valid/ready handshake with 1-cycle latency
  - full opcode coverage: load, store, branch, LUI, AUIPC, JAL, JALR
  - immediate generation
  - illegal-instruction detection, plus a saturating counter of illegal instructions

Parameters:
- XLEN, 32, datapath width. Legal values are 32 or 64; it sets the immediate/PC width and the legal load/store sizes.
- CNT_W, 16, width of illegal_count.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  in_instr/in_pc valid
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  XLEN  registered in_pc
- out_rs1, out_rs2, out_rd  out  5 each  register indices; forced to 0 where unused
- out_imm  out  XLEN  sign-extended immediate
- out_alu_ctrl  out  4  ALU op (package encoding)
- out_regwrite, out_imm_sel, out_mem_read, out_mem_write  out  1 each  datapath controls
- out_mem_size  out  3  funct3 for loads/stores, 0 otherwise
- out_branch, out_jump, out_pc_rel  out  1 each  branch / JAL-JALR / AUIPC-JAL use PC as ALU operand A
- out_muldiv  out  1  M-extension op
- out_illegal  out  1  bundle is an illegal instruction
- illegal_count  out  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_alu_ctrl=4'b1111, illegal_count=0.
  - Every other output is 0.
- in_ready = !out_valid || out_ready. It is purely combinational and does not depend on flush.
- Transfer: a transfer occurs when in_valid && in_ready.
  - The decoded bundle is registered on that edge and out_valid=1 the next cycle (latency 1).
  - Back-to-back transfers sustain 1 per cycle.
- Stall: while out_valid && !out_ready, all out_* hold stable.
- No transfer and out_ready=1: out_valid falls to 0.
- Flush: when flush=1, out_valid goes to 0 next cycle and any same-cycle transfer is discarded.
  - illegal_count is not incremented by a discarded transfer.
- Decode by opcode:
  - R 0110011, ALU from {funct7[5],funct3}:
    - ADD 0010, SUB 0100, SLL 0011, SLT 1000, SLTU 0110, XOR 0111, SRL 0101, SRA 1001, OR 0001, AND 0000.
    - funct7 must be 0000000, or 0100000 only for ADD/SUB and SRL/SRA.
  - I-ALU 0010011: same encodings, with funct7[5] ignored except for shifts.
    - SLLI needs upper bits 0.
    - SRLI/SRAI need upper bits 0000000/0100000.
    - For XLEN=64, imm[5] is part of shamt.
  - LOAD 0000011: regwrite, imm_sel, mem_read, ALU ADD, I-imm.
    - Legal funct3: 000/001/010/100/101. XLEN=64 adds 011 and 110.
  - STORE 0100011: mem_write, imm_sel, ALU ADD, S-imm, rd=0.
    - Legal funct3: 000–010. XLEN=64 adds 011.
  - BRANCH 1100011: branch, B-imm, rd=0.
    - ALU SUB for funct3 000/001, SLT for 100/101, SLTU for 110/111. 010/011 are illegal.
  - LUI 0110111: regwrite, imm_sel, ADD, rs1=0, U-imm.
  - AUIPC 0010111: LUI controls plus pc_rel.
  - JAL 1101111: regwrite, jump, pc_rel, J-imm.
  - JALR 1100111: regwrite, jump, imm_sel, ADD, I-imm. funct3 must be 000.
- Unused register fields are 0.
- Immediates are sign-extended from instr[31] to XLEN.
- Illegal instruction (unlisted opcode or illegal field combination):
  - all control outputs 0, out_alu_ctrl=1111, out_illegal=1.
  - out_pc and out_imm are still registered.
- illegal_count increments on each accepted, unflushed illegal transfer and saturates at all-ones (no wrap).

Optional Feature:
- DECODE_M_EXT_EN defined: R-type with funct7=0000001 decodes as an M-extension op.
  - out_muldiv=1, out_alu_ctrl={1'b0,funct3}, out_regwrite=1.
- DECODE_M_EXT_EN undefined: these encodings are illegal and out_muldiv is tied 0.

Decomposition:
- Package decode_pkg holds:
  - opcode constants
  - ALU_* 4-bit localparams, including ALU_INVALID=4'b1111
  - the decoded-bundle struct typedef
  - the immediate-type enum (I/S/B/U/J)
- Sub-module decode_comb: a purely combinational instr→bundle decoder.
- decode_stage holds the handshake register, flush logic and counter.

Test Plan:
- ADD x3,x1,x2 (0x002081B3) with in_valid=1, out_ready=1:
  - next cycle out_valid=1, alu=0010, rd=3, rs1=1, rs2=2, regwrite=1, illegal=0.
- LW x5,-4(x2) (0xFFC12283):
  - mem_read=1, mem_write=0, alu=0010, imm=0xFFFFFFFC, mem_size=010.
- Hold out_ready=0 for 3 cycles after a transfer:
  - in_ready=0 and outputs are stable.
  - When out_ready rises, the second instruction is accepted that cycle.
- Opcode 0x0000007F, then 0x00000000 (both illegal) with CNT_W=2, repeated 5 times:
  - out_illegal=1, alu=1111, illegal_count=1,2,3,3,3.
- Assert flush in the same cycle as a transfer of an illegal instruction:
  - out_valid=0 next cycle and illegal_count is unchanged.
- MUL x1,x2,x3 (0x023100B3):
  - with DECODE_M_EXT_EN, muldiv=1 and alu=0000.
  - without it, illegal=1.
- Drop rst_n mid-stall: outputs go to reset values immediately, without waiting for a clock edge.
